// File: rtl/fir_dec_avl_st.sv
// Decimating FIR stage between two Avalon-ST packet interfaces: header pass-through, filtered/decimated payload, status trailer.
// Optional round-half-up before the output shift when FIR_DEC_ROUND_EN is defined (truncation otherwise).
module fir_dec_avl_st #(
  parameter int DATA_WIDTH   = 16,
  parameter int COEF_WIDTH   = 16,
  parameter int COEF_FRAC    = 14,
  parameter int TAPS         = 8,
  parameter int FACTOR       = 2,
  parameter int HEADER_WORDS = 3,
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  coef_wr,
  input  logic [AW-1:0]         coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_data,
  output logic                  busy,
  output logic [15:0]           pkt_count,
  output logic                  drop_pulse
);

  localparam int GW    = (TAPS > 1) ? $clog2(TAPS) : 0;
  localparam int PW    = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W = PW + GW + 1;
  localparam int HW    = $clog2(HEADER_WORDS + 1);
  localparam int PHW   = (FACTOR > 1) ? $clog2(FACTOR) : 1;

  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1) << COEF_FRAC;
`ifdef FIR_DEC_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (COEF_FRAC - 1);
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  state_t                        state_reg, state_next;
  logic                          out_valid_reg, out_sop_reg, out_eop_reg;
  logic [DATA_WIDTH-1:0]         out_data_reg;
  logic [HW-1:0]                 hdr_cnt_reg, hdr_cnt_next;
  logic [PHW-1:0]                phase_reg, phase_next;
  logic                          sop_err_reg, sop_err_next;
  logic                          sat_reg, sat_next;
  logic [15:0]                   pkt_count_reg;
  logic                          drop_pulse_reg, drop_next;
  logic signed [DATA_WIDTH-1:0]  delay_reg [TAPS];
  logic signed [COEF_WIDTH-1:0]  coef_reg  [TAPS];

  logic signed [DATA_WIDTH-1:0]  x_next [TAPS];
  logic signed [PW-1:0]          prod   [TAPS];
  logic signed [ACC_W-1:0]       acc, shifted;
  logic [DATA_WIDTH-1:0]         y_sat;
  logic                          clip;

  logic                          accept, load, shift_en, clr_line, pkt_inc, coef_we;
  logic                          o_sop, o_eop;
  logic [DATA_WIDTH-1:0]         o_data;

  assign in_ready   = !out_valid_reg || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_reg;
  assign out_sop    = out_sop_reg;
  assign out_eop    = out_eop_reg;
  assign out_data   = out_data_reg;
  assign busy       = (state_reg != IDLE);
  assign pkt_count  = pkt_count_reg;
  assign drop_pulse = drop_pulse_reg;
  assign coef_we    = coef_wr && (state_reg == IDLE) && !accept && (32'(coef_addr) < TAPS);

  // Filter evaluates on the line as it will look after the incoming sample shifts in.
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign x_next[gi] = in_data;
      end else begin : g_body
        assign x_next[gi] = delay_reg[gi-1];
      end
      assign prod[gi] = PW'(x_next[gi]) * PW'(coef_reg[gi]);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          delay_reg[gi] <= '0;
          coef_reg[gi]  <= (gi == 0) ? COEF_ONE : '0;
        end else begin
          if (clr_line)      delay_reg[gi] <= '0;
          else if (shift_en) delay_reg[gi] <= x_next[gi];
          if (coef_we && (32'(coef_addr) == gi)) coef_reg[gi] <= coef_data;
        end
      end
    end
  endgenerate

  always_comb begin
    acc = RND;
    for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(prod[k]);
    shifted = acc >>> COEF_FRAC;
    clip    = 1'b0;
    y_sat   = shifted[DATA_WIDTH-1:0];
    if (shifted > MAXV) begin
      clip  = 1'b1;
      y_sat = MAXV[DATA_WIDTH-1:0];
    end else if (shifted < MINV) begin
      clip  = 1'b1;
      y_sat = MINV[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_next   = state_reg;
    hdr_cnt_next = hdr_cnt_reg;
    phase_next   = phase_reg;
    sop_err_next = sop_err_reg;
    sat_next     = sat_reg;
    drop_next    = 1'b0;
    load         = 1'b0;
    shift_en     = 1'b0;
    clr_line     = 1'b0;
    pkt_inc      = 1'b0;
    o_sop        = 1'b0;
    o_eop        = 1'b0;
    o_data       = in_data;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (in_sop && in_eop) begin
            load    = 1'b1;
            o_sop   = 1'b1;
            o_eop   = 1'b1;
            o_data  = {in_data[DATA_WIDTH-1:3], 3'b001};
            pkt_inc = 1'b1;
          end else if (in_sop) begin
            load         = 1'b1;
            o_sop        = 1'b1;
            sop_err_next = 1'b0;
            sat_next     = 1'b0;
            phase_next   = '0;
            clr_line     = 1'b1;
            hdr_cnt_next = HW'(1);
            state_next   = (HEADER_WORDS == 1) ? DATA : HEADER;
          end else begin
            drop_next = 1'b1;
          end
        end
        HEADER, DATA: begin
          if (in_eop) begin
            // Trailer: short only when the header never completed.
            load       = 1'b1;
            o_eop      = 1'b1;
            o_data     = {in_data[DATA_WIDTH-1:3], sop_err_reg | in_sop, sat_reg,
                          state_reg == HEADER};
            pkt_inc    = 1'b1;
            clr_line   = 1'b1;
            phase_next = '0;
            state_next = IDLE;
          end else if (state_reg == HEADER) begin
            load         = 1'b1;
            sop_err_next = sop_err_reg | in_sop;
            hdr_cnt_next = hdr_cnt_reg + HW'(1);
            if (hdr_cnt_reg == HW'(HEADER_WORDS - 1)) state_next = DATA;
          end else begin
            shift_en     = 1'b1;
            sop_err_next = sop_err_reg | in_sop;
            phase_next   = (phase_reg == PHW'(FACTOR - 1)) ? '0 : phase_reg + PHW'(1);
            if (phase_reg == '0) begin
              load     = 1'b1;
              o_data   = y_sat;
              sat_next = sat_reg | clip;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      hdr_cnt_reg    <= '0;
      phase_reg      <= '0;
      sop_err_reg    <= 1'b0;
      sat_reg        <= 1'b0;
      pkt_count_reg  <= '0;
      drop_pulse_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_sop_reg    <= 1'b0;
      out_eop_reg    <= 1'b0;
      out_data_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      hdr_cnt_reg    <= hdr_cnt_next;
      phase_reg      <= phase_next;
      sop_err_reg    <= sop_err_next;
      sat_reg        <= sat_next;
      drop_pulse_reg <= drop_next;
      if (pkt_inc) pkt_count_reg <= pkt_count_reg + 16'd1;
      if (load) begin
        out_valid_reg <= 1'b1;
        out_sop_reg   <= o_sop;
        out_eop_reg   <= o_eop;
        out_data_reg  <= o_data;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_dec_avl_st.sv
// Directed bench for fir_dec_avl_st: one FACTOR=1 instance and one FACTOR=2 instance, selected by sel.
module tb_fir_dec_avl_st;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        coef_wr = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;

  logic        in_ready_a, out_valid_a, out_sop_a, out_eop_a, busy_a, drop_a;
  logic [15:0] out_data_a, pkt_a;
  logic        in_ready_b, out_valid_b, out_sop_b, out_eop_b, busy_b, drop_b;
  logic [15:0] out_data_b, pkt_b;

  logic        m_ready, m_valid, m_sop, m_eop, m_busy, m_drop;
  logic [15:0] m_data, m_pkt;

  int          n_cmp = 0, n_err = 0;
  logic [17:0] q[$];
  logic [17:0] eq[$];
  logic [15:0] exp_rnd;

  always #5 clk = ~clk;

  fir_dec_avl_st #(.FACTOR(1)) u_dut_a (
    .clk(clk), .reset(reset), .in_ready(in_ready_a), .in_valid(in_valid && !sel),
    .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data), .out_ready(out_ready),
    .out_valid(out_valid_a), .out_sop(out_sop_a), .out_eop(out_eop_a), .out_data(out_data_a),
    .coef_wr(coef_wr && !sel), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy_a), .pkt_count(pkt_a), .drop_pulse(drop_a));

  fir_dec_avl_st #(.FACTOR(2)) u_dut_b (
    .clk(clk), .reset(reset), .in_ready(in_ready_b), .in_valid(in_valid && sel),
    .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data), .out_ready(out_ready),
    .out_valid(out_valid_b), .out_sop(out_sop_b), .out_eop(out_eop_b), .out_data(out_data_b),
    .coef_wr(coef_wr && sel), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy_b), .pkt_count(pkt_b), .drop_pulse(drop_b));

  assign m_ready = sel ? in_ready_b  : in_ready_a;
  assign m_valid = sel ? out_valid_b : out_valid_a;
  assign m_sop   = sel ? out_sop_b   : out_sop_a;
  assign m_eop   = sel ? out_eop_b   : out_eop_a;
  assign m_data  = sel ? out_data_b  : out_data_a;
  assign m_busy  = sel ? busy_b      : busy_a;
  assign m_drop  = sel ? drop_b      : drop_a;
  assign m_pkt   = sel ? pkt_b       : pkt_a;

  always @(negedge clk) begin
    if (!reset && m_valid && out_ready) begin
      q.push_back({m_sop, m_eop, m_data});
      $display("out dut=%0d sop=%b eop=%b data=0x%04h", sel, m_sop, m_eop, m_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic sop, input logic eop, input logic [15:0] d);
    bit done = 1'b0;
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (m_ready) done = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    n_cmp++;
    assert (done) else begin
      n_err++;
      $error("FAIL send_timeout observed=%0d expected=1", done);
    end
  endtask

  task automatic wcoef(input logic [2:0] a, input logic [15:0] v);
    coef_wr = 1'b1; coef_addr = a; coef_data = v;
    @(posedge clk); #1;
    coef_wr = 1'b0;
  endtask

  task automatic ew(input logic sop, input logic eop, input logic [15:0] d);
    eq.push_back({sop, eop, d});
  endtask

  task automatic hdr3();
    send(1, 0, 16'hA000); send(0, 0, 16'hA001); send(0, 0, 16'hA002);
    ew(1, 0, 16'hA000); ew(0, 0, 16'hA001); ew(0, 0, 16'hA002);
  endtask

  task automatic check_out(input string tag);
    int n;
    for (int i = 0; i < 200 && q.size() < eq.size(); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, q.size(), eq.size());
    n = (q.size() < eq.size()) ? q.size() : eq.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), {14'd0, q[i]}, {14'd0, eq[i]});
    q.delete(); eq.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] held;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", out_valid_a, 0);
    chk("rst_data", out_data_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_pkt", pkt_a, 0);
    chk("rst_drop", drop_a, 0);
    chk("rst_ready", in_ready_a, 1);

    // Pass-through with reset coefficients.
    hdr3(); send(0, 0, 16'd100); send(0, 0, 16'hFFFB); send(0, 1, 16'h0008);
    ew(0, 0, 16'd100); ew(0, 0, 16'hFFFB); ew(0, 1, 16'h0008);
    check_out("pass");
    chk("pass_pkt", m_pkt, 1);
    chk("pass_busy", m_busy, 0);

    // EOP on header word 1.
    send(1, 0, 16'h1111); send(0, 1, 16'h2220);
    ew(1, 0, 16'h1111); ew(0, 1, 16'h2221);
    check_out("short");
    chk("short_pkt", m_pkt, 2);

    // Non-SOP word while idle.
    send(0, 0, 16'h5555);
    chk("drop_hi", m_drop, 1);
    @(posedge clk); #1;
    chk("drop_lo", m_drop, 0);
    check_out("drop");
    chk("drop_pkt", m_pkt, 2);

    // SOP flag mid-packet.
    hdr3(); send(1, 0, 16'd7); send(0, 1, 16'h0000);
    ew(0, 0, 16'd7); ew(0, 1, 16'h0004);
    check_out("soperr");
    chk("soperr_pkt", m_pkt, 3);

    // Rounding of 3 * 0.5.
`ifdef FIR_DEC_ROUND_EN
    exp_rnd = 16'd2;
`else
    exp_rnd = 16'd1;
`endif
    wcoef(0, 16'h2000);
    hdr3(); send(0, 0, 16'd3); send(0, 1, 16'h0000);
    ew(0, 0, exp_rnd); ew(0, 1, 16'h0000);
    check_out("round");

    // Coefficient write during DATA is ignored.
    hdr3(); send(0, 0, 16'd4);
    wcoef(0, 16'h4000);
    send(0, 0, 16'd6); send(0, 1, 16'h0000);
    ew(0, 0, 16'd2); ew(0, 0, 16'd3); ew(0, 1, 16'h0000);
    check_out("cwr_data");
    hdr3(); send(0, 0, 16'd8); send(0, 1, 16'h0000);
    ew(0, 0, 16'd4); ew(0, 1, 16'h0000);
    check_out("cwr_next");

    // Saturation both directions.
    wcoef(0, 16'h7FFF);
    hdr3(); send(0, 0, 16'h7FFF); send(0, 0, 16'h8000); send(0, 1, 16'h0000);
    ew(0, 0, 16'h7FFF); ew(0, 0, 16'h8000); ew(0, 1, 16'h0002);
    check_out("sat");

    // Five-cycle downstream stall mid-payload.
    wcoef(0, 16'h4000);
    fork
      begin
        hdr3();
        for (int s = 1; s <= 8; s++) send(0, 0, 16'(s));
        send(0, 1, 16'h0010);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          held = m_data;
          chk($sformatf("stall_valid%0d", i), m_valid, 1);
          chk($sformatf("stall_data%0d", i), held, 16'd3);
          chk($sformatf("stall_ready%0d", i), m_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    for (int s = 1; s <= 8; s++) ew(0, 0, 16'(s));
    ew(0, 1, 16'h0010);
    check_out("stall");

    // SOP and EOP on the same word while idle.
    send(1, 1, 16'h00F0);
    ew(1, 1, 16'h00F1);
    check_out("sopeop");

    // Decimation by 2 with two half-weight taps.
    sel = 1'b1;
    @(posedge clk); #1;
    wcoef(0, 16'h2000); wcoef(1, 16'h2000);
    hdr3();
    send(0, 0, 16'd10); send(0, 0, 16'd20); send(0, 0, 16'd30); send(0, 0, 16'd40);
    send(0, 1, 16'h0000);
    ew(0, 0, 16'd5); ew(0, 0, 16'd25); ew(0, 1, 16'h0000);
    check_out("decim");
    chk("decim_pkt", m_pkt, 1);

    // Reset mid-packet abandons the packet without a trailer.
    sel = 1'b0;
    @(posedge clk); #1;
    send(1, 0, 16'hB000); send(0, 0, 16'hB001);
    chk("mid_busy", m_busy, 1);
    ew(1, 0, 16'hB000); ew(0, 0, 16'hB001);
    check_out("mid_partial");
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", m_busy, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_pkt", m_pkt, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_no_trailer", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
